// File: rtl/calc_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Package   : calc_pkg                                             |
// | Purpose   : Shared op codes, FSM states and result constants     |
// |             for the calculator arithmetic engine.                |
// | Revision  : 1.0  initial release                                 |
// +------------------------------------------------------------------+
package calc_pkg;

  localparam int RES_W = 32;
  localparam logic [RES_W-1:0] ERR_CODE_DEF = 32'hEEEE_EEEE;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage
`default_nettype wire

// File: rtl/calc_seq_muldiv.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module    : calc_seq_muldiv                                      |
// | Purpose   : WIDTH-cycle shared shift datapath: shift-add multiply|
// |             (LSB first) and restoring divide (MSB first).        |
// | Revision  : 1.0  initial release                                 |
// +------------------------------------------------------------------+
module calc_seq_muldiv #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 go,
  input  logic                 is_div,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  // Upper half: accumulator (MUL) or partial remainder (DIV).
  // Lower half: multiplier bits still to consume (MUL) or dividend/quotient (DIV).
  logic [2*WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0]   d_q;       // multiplicand (MUL) or divisor (DIV)
  logic               div_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               run_q;

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     shifted;
  logic [WIDTH-1:0]   rem_sub;
  logic               ge;

  // One iteration step; the final step's value is also the result output.
  always_comb begin
    sum     = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, (p_q[0] ? d_q : {WIDTH{1'b0}})};
    shifted = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
    ge      = (shifted >= {1'b0, d_q});
    // When ge holds the true difference is below the divisor, so the low bits suffice.
    rem_sub = shifted[WIDTH-1:0] - d_q;
    if (div_q) begin
      p_d = {(ge ? rem_sub : shifted[WIDTH-1:0]), p_q[WIDTH-2:0], ge};
    end else begin
      p_d = {sum, p_q[WIDTH-1:1]};
    end
  end

  // Load on go, then iterate WIDTH times.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q   <= '0;
      d_q   <= '0;
      div_q <= 1'b0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (go) begin
      p_q   <= {{WIDTH{1'b0}}, (is_div ? a : b)};
      d_q   <= is_div ? b : a;
      div_q <= is_div;
      cnt_q <= CNT_W'(WIDTH);
      run_q <= 1'b1;
    end else if (run_q) begin
      p_q   <= p_d;
      cnt_q <= cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        run_q <= 1'b0;
      end
    end
  end

  assign done   = run_q && (cnt_q == CNT_W'(1));
  assign result = p_d;

endmodule
`default_nettype wire

// File: rtl/calculator_core.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module    : calculator_core                                      |
// | Purpose   : Arithmetic engine: 1-cycle add/sub, WIDTH-cycle      |
// |             mul/div, 32-bit held result with valid pulse.        |
// | Revision  : 1.0  initial release                                 |
// +------------------------------------------------------------------+
module calculator_core
  import calc_pkg::*;
#(
  parameter int               WIDTH    = 16,
  parameter logic [RES_W-1:0] ERR_CODE = ERR_CODE_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [WIDTH-1:0]  operand_a,
  input  logic [WIDTH-1:0]  operand_b,
  output logic              busy,
  output logic              result_valid,
  output logic              err,
  output logic [RES_W-1:0]  cal_result
);

  state_e             state_q;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic               busy_q, valid_q, err_q;
  logic [RES_W-1:0]   result_q;

  logic               accept, md_go, md_done, div0, fast;
  logic [2*WIDTH-1:0] md_result;
  logic [RES_W-1:0]   ext_a, ext_b, fast_result;

  // DONE is the last busy cycle; a start there lands on the edge the core frees up.
  assign accept = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign md_go  = accept && ((op == OP_MUL) || ((op == OP_DIV) && (operand_b != '0)));

  assign div0  = (op_q == OP_DIV) && (b_q == '0);
  assign fast  = (op_q == OP_ADD) || (op_q == OP_SUB) || div0;
  assign ext_a = {{(RES_W-WIDTH){1'b0}}, a_q};
  assign ext_b = {{(RES_W-WIDTH){1'b0}}, b_q};
  // 32-bit subtraction of zero-extended operands yields the sign-extended difference.
  assign fast_result = div0 ? ERR_CODE
                     : ((op_q == OP_SUB) ? (ext_a - ext_b) : (ext_a + ext_b));

  calc_seq_muldiv #(
    .WIDTH  (WIDTH)
  ) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .go     (md_go),
    .is_div (operand_b != '0 && op == OP_DIV),
    .a      (operand_a),
    .b      (operand_b),
    .done   (md_done),
    .result (md_result)
  );

  // Control FSM with registered outputs; result_valid defaults low to form a pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_ADD;
      a_q      <= '0;
      b_q      <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      result_q <= '0;
    end else begin
      valid_q <= 1'b0;
      if (accept) begin
        op_q    <= op;
        a_q     <= operand_a;
        b_q     <= operand_b;
        err_q   <= 1'b0;
        busy_q  <= 1'b1;
        state_q <= ST_CALC;
      end else begin
        case (state_q)
          ST_CALC: begin
            if (fast || md_done) begin
              result_q <= fast ? fast_result : md_result;
              err_q    <= div0;
              valid_q  <= 1'b1;
              state_q  <= ST_DONE;
            end
          end
          ST_DONE: begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
          default: begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign busy         = busy_q;
  assign result_valid = valid_q;
  assign err          = err_q;
  assign cal_result   = result_q;

endmodule
`default_nettype wire
